// File: rtl/final_nios2_debug_pkg.sv
// final_nios2_debug_pkg: shared command codes, store states and command record for the debug link
package final_nios2_debug_pkg;
  typedef enum logic [1:0] {
    CMD_OCIMEM    = 2'd0,
    CMD_TRACEMEM  = 2'd1,
    CMD_BREAK     = 2'd2,
    CMD_TRACECTRL = 2'd3
  } cmd_e;
  typedef enum logic {ST_EMPTY, ST_FULL} store_e;
  localparam int ACTION_OFS = 3;
  localparam int DEF_IR_W = 2;
  localparam int DEF_SR_W = 38;
  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } cmd_t;
  function automatic int action_bit(input int sr_w);
    return sr_w - ACTION_OFS;
  endfunction
endpackage

// File: rtl/final_nios2_debug_pulse_sync.sv
// final_nios2_debug_pulse_sync: level synchroniser with post-reset arming and registered rising-edge pulse
module final_nios2_debug_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_MAX = AW'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  logic [AW-1:0] arm;
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
      arm   <= '0;
      pulse <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      arm   <= (arm == ARM_MAX) ? arm : arm + 1'b1;
      pulse <= (arm == ARM_MAX) && chain[SYNC_STAGES-1] && !prev;
    end
  end
endmodule

// File: rtl/final_nios2_debug_cmd_sync.sv
// final_nios2_debug_cmd_sync: sysclk side of the JTAG debug link; DEBUG_CMD_FIFO_EN selects a FIFO_DEPTH-entry command queue
module final_nios2_debug_cmd_sync
  import final_nios2_debug_pkg::*;
#(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vs_udr,
  input  logic                  vs_uir,
  input  logic [IR_W-1:0]       ir_in,
  input  logic [SR_W-1:0]       sr,
  output logic [SR_W-1:0]       jdo,
  output logic [(1<<IR_W)-1:0]  take_action,
  output logic [(1<<IR_W)-1:0]  take_no_action,
  output logic                  ir_strobe,
  output logic [IR_W-1:0]       ir_q,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [IR_W-1:0]       cmd_ir,
  output logic [SR_W-1:0]       cmd_data,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_overflow
);
  localparam int N_CMD = 1 << IR_W;
  localparam int ACT = action_bit(SR_W);
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;
  if (SR_W < 3 || SYNC_STAGES < 2 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("final_nios2_debug_cmd_sync: unsupported parameter set");
  end
  logic upd, uir, drop;
  logic [N_CMD-1:0] sel;
  entry_t head;
  final_nios2_debug_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr (
    .clk(clk), .reset(reset), .din(vs_udr), .pulse(upd)
  );
  final_nios2_debug_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir (
    .clk(clk), .reset(reset), .din(vs_uir), .pulse(uir)
  );
  assign sel = N_CMD'(1) << ir_in;
  assign ir_strobe = uir;
  assign cmd_ir = head.ir;
  assign cmd_data = head.data;
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_q           <= '0;
    end else begin
      take_action    <= (upd && sr[ACT]) ? sel : '0;
      take_no_action <= (upd && !sr[ACT]) ? sel : '0;
      if (upd) jdo <= sr;
      if (uir) ir_q <= ir_in;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_overflow ? DROP_CNT_W'(1) : ((&drop_cnt) ? drop_cnt : drop_cnt + 1'b1);
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end
`ifdef DEBUG_CMD_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  entry_t mem [FIFO_DEPTH];
  logic [PW-1:0] rd, wr;
  logic [PW:0] cnt;
  logic pop, push, full_q;
  assign full_q = cnt == (PW+1)'(FIFO_DEPTH);
  assign pop = cmd_ready && cnt != '0;
  assign push = upd && (!full_q || pop);
  assign drop = upd && full_q && !pop;
  assign cmd_valid = cnt != '0;
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr] <= '{ir: ir_in, data: sr};
        wr      <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
`else
  store_e state;
  entry_t ent;
  assign drop = upd && state == ST_FULL && !cmd_ready;
  assign cmd_valid = state == ST_FULL;
  assign head = ent;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      ent   <= '0;
    end else if (upd && (state == ST_EMPTY || cmd_ready)) begin
      state <= ST_FULL;
      ent   <= '{ir: ir_in, data: sr};
    end else if (cmd_ready) begin
      state <= ST_EMPTY;
    end
  end
`endif
endmodule
